// File: rtl/led_pattern_classifier_if.sv
// LED-bus monitor interface: sequencer-side signals in, classification out.
// The master modport belongs to whoever drives the LED bus and step tick.
// The slave modport belongs to the classifier.
interface led_pattern_classifier_if;
  logic [7:0] led_in;
  logic       step;
  logic [4:0] pattern_id;
  logic       locked;
  logic       lost;
  logic [3:0] run_len;

  modport master (
    output led_in, step,
    input  pattern_id, locked, lost, run_len
  );

  modport slave (
    input  led_in, step,
    output pattern_id, locked, lost, run_len
  );
endinterface

// File: rtl/led_pattern_classifier.sv
// Receive-side monitor for the multi-pattern LED sequencer.
// The LED bus is sampled on each step tick, and each transition prev->cur is
// classified against the known patterns. The classifier tracks which patterns
// stay consistent and locks once exactly one pattern survives for LOCK_STEPS
// steps. pattern_id uses the sequencer's pattern_sel encoding, where 31 means
// unknown.
module led_pattern_classifier #(
  parameter int LOCK_STEPS     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      rst_n,
  led_pattern_classifier_if.slave   bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_TRACK  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam logic [3:0]  C_LOCK_STEPS = 4'(LOCK_STEPS);
  localparam logic [15:0] C_TIMEOUT    = 16'(TIMEOUT_CYCLES);
  localparam logic [4:0]  C_UNKNOWN    = 5'd31;

  // Match-mask bit positions
  localparam int B_OFF    = 0;
  localparam int B_ON     = 1;
  localparam int B_BLINK  = 2;
  localparam int B_RUN    = 3;
  localparam int B_ALT    = 4;
  localparam int B_NEGRUN = 5;
  localparam int B_COUNT  = 6;

  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

  function automatic logic is_onehot7(input logic [6:0] v);
    return (v != 7'h00) && ((v & (v - 7'h01)) == 7'h00);
  endfunction

  // The lowest set bit wins, so an ambiguous mask still reports a stable code.
  function automatic logic [4:0] mask_to_code(input logic [6:0] m);
    logic [4:0] code;
    code = C_UNKNOWN;
    if      (m[B_OFF])    code = 5'd0;
    else if (m[B_ON])     code = 5'd1;
    else if (m[B_BLINK])  code = 5'd2;
    else if (m[B_RUN])    code = 5'd3;
    else if (m[B_ALT])    code = 5'd4;
    else if (m[B_NEGRUN]) code = 5'd5;
    else if (m[B_COUNT])  code = 5'd13;
    return code;
  endfunction

  logic [1:0]  r_state;
  logic [7:0]  r_prev;
  logic [6:0]  r_mask;
  logic [3:0]  r_run_len;
  logic [4:0]  r_pattern_id;
  logic        r_locked;
  logic        r_lost;
  logic [15:0] r_cnt;

  logic [6:0]  w_match;
  logic [6:0]  w_and;
  logic [7:0]  w_rotl;
  logic [3:0]  w_run_inc;
  logic [3:0]  w_run_fresh;
  logic [15:0] w_cnt_inc;
  logic        w_timeout;

  logic [1:0]  w_state_nxt;
  logic [7:0]  w_prev_nxt;
  logic [6:0]  w_mask_nxt;
  logic [3:0]  w_run_nxt;
  logic [4:0]  w_pid_nxt;
  logic        w_locked_nxt;
  logic        w_lost_nxt;
  logic [15:0] w_cnt_nxt;

  // Classify the transition from the previous sample to the current LED bus
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
    w_match         = '0;
    w_rotl          = {r_prev[6:0], r_prev[7]};
    w_match[B_OFF]    = (r_prev == 8'h00) && (bus.led_in == 8'h00);
    w_match[B_ON]     = (r_prev == 8'hFF) && (bus.led_in == 8'hFF);
    w_match[B_BLINK]  = ((r_prev == 8'h00) && (bus.led_in == 8'hFF)) ||
                        ((r_prev == 8'hFF) && (bus.led_in == 8'h00));
    w_match[B_RUN]    = is_onehot8(r_prev) && (bus.led_in == w_rotl);
    w_match[B_ALT]    = ((r_prev == 8'hAA) || (r_prev == 8'h55)) &&
                        (bus.led_in == ~r_prev);
    w_match[B_NEGRUN] = is_onehot8(~r_prev) && (bus.led_in == w_rotl);
    w_match[B_COUNT]  = (bus.led_in == r_prev + 8'h01);
  end

  assign w_and       = r_mask & w_match;
  assign w_run_inc   = (r_run_len == 4'hF) ? 4'hF : r_run_len + 4'h1;
  assign w_run_fresh = (w_match != 7'h00) ? 4'h1 : 4'h0;
  assign w_cnt_inc   = (r_cnt == 16'hFFFF) ? 16'hFFFF : r_cnt + 16'h0001;
  assign w_timeout   = (C_TIMEOUT != 16'h0000) && (w_cnt_inc >= C_TIMEOUT);

  // Next-state logic: process a step, otherwise check for a step timeout
  always_comb begin
    w_state_nxt  = r_state;
    w_prev_nxt   = r_prev;
    w_mask_nxt   = r_mask;
    w_run_nxt    = r_run_len;
    w_pid_nxt    = r_pattern_id;
    w_locked_nxt = r_locked;
    w_lost_nxt   = 1'b0;
    w_cnt_nxt    = bus.step ? 16'h0000 : w_cnt_inc;

    if (bus.step) begin
      w_prev_nxt = bus.led_in;
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_TRACK;
        end
        S_TRACK: begin
          if (w_and != 7'h00) begin
            w_mask_nxt = w_and;
            w_run_nxt  = w_run_inc;
          end else begin
            w_mask_nxt = w_match;
            w_run_nxt  = w_run_fresh;
          end
          w_pid_nxt = mask_to_code(w_mask_nxt);
          // An ambiguous mask never locks, however long the run
          if ((w_run_nxt >= C_LOCK_STEPS) && is_onehot7(w_mask_nxt)) begin
            w_state_nxt  = S_LOCKED;
            w_locked_nxt = 1'b1;
          end
        end
        S_LOCKED: begin
          if (w_and != 7'h00) begin
            w_run_nxt = w_run_inc;
          end else begin
            w_locked_nxt = 1'b0;
            w_lost_nxt   = 1'b1;
            w_state_nxt  = S_TRACK;
            w_mask_nxt   = w_match;
            w_run_nxt    = w_run_fresh;
            w_pid_nxt    = mask_to_code(w_match);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end else if (w_timeout && (r_state != S_IDLE)) begin
      // The sequencer stalled, so forget everything; only a held lock reports loss
      w_lost_nxt   = (r_state == S_LOCKED);
      w_locked_nxt = 1'b0;
      w_pid_nxt    = C_UNKNOWN;
      w_mask_nxt   = 7'h00;
      w_run_nxt    = 4'h0;
      w_state_nxt  = S_IDLE;
    end
  end

  // Register all state and outputs; the synchronous reset overrides any step
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_prev       <= 8'h00;
      r_mask       <= 7'h00;
      r_run_len    <= 4'h0;
      r_pattern_id <= C_UNKNOWN;
      r_locked     <= 1'b0;
      r_lost       <= 1'b0;
      r_cnt        <= 16'h0000;
    end else begin
      r_state      <= w_state_nxt;
      r_prev       <= w_prev_nxt;
      r_mask       <= w_mask_nxt;
      r_run_len    <= w_run_nxt;
      r_pattern_id <= w_pid_nxt;
      r_locked     <= w_locked_nxt;
      r_lost       <= w_lost_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  assign bus.pattern_id = r_pattern_id;
  assign bus.locked     = r_locked;
  assign bus.lost       = r_lost;
  assign bus.run_len    = r_run_len;

endmodule

// File: tb/tb_led_pattern_classifier.sv
// Directed bench for led_pattern_classifier. Each table row is one step,
// followed by one idle cycle, together with the outputs expected after that
// step. Hand-written sequences cover the timeout and the mid-lock reset.
module tb_led_pattern_classifier;

  localparam int LOCK     = 4;
  localparam int TIMEOUT  = 16;

  logic clk;
  logic rst_n;

  led_pattern_classifier_if bus ();

  led_pattern_classifier #(
    .LOCK_STEPS     (LOCK),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] led;
    logic [4:0] pid;
    logic       lk;
    logic       ls;
    logic [3:0] rl;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [7:0] led, input logic [4:0] pid,
                              input logic lk, input logic ls, input logic [3:0] rl);
    vec_t v;
    v.led = led; v.pid = pid; v.lk = lk; v.ls = ls; v.rl = rl;
    vecs.push_back(v);
  endfunction

  task automatic check_outs(input string tag, input logic [4:0] pid,
                            input logic lk, input logic ls, input logic [3:0] rl);
    check({tag, " pattern_id"}, 32'(bus.pattern_id), 32'(pid));
    check({tag, " locked"},     32'(bus.locked),     32'(lk));
    check({tag, " lost"},       32'(bus.lost),       32'(ls));
    check({tag, " run_len"},    32'(bus.run_len),    32'(rl));
  endtask

  task automatic idle_cycle();
    bus.step = 1'b0;
    @(posedge clk); #1;
  endtask

  // One step, a check after its edge, then an idle cycle that must clear lost
  task automatic do_step(input string tag, input logic [7:0] led, input logic [4:0] pid,
                         input logic lk, input logic ls, input logic [3:0] rl);
    bus.led_in = led;
    bus.step   = 1'b1;
    @(posedge clk); #1;
    check_outs(tag, pid, lk, ls, rl);
    idle_cycle();
    check({tag, " idle lost"}, 32'(bus.lost), 32'h0);
    check({tag, " idle pid"},  32'(bus.pattern_id), 32'(pid));
  endtask

  initial begin
    logic [7:0] rnd [12];
    rnd = '{8'h3C, 8'h91, 8'h17, 8'hE2, 8'h6B, 8'hC4,
            8'h5D, 8'hA0, 8'h39, 8'h7E, 8'hD3, 8'h48};

    // RUN: first step only loads prev, 01->02 is ambiguous (RUN|COUNT)
    add(8'h01, 5'd31, 0, 0, 0);
    add(8'h02, 5'd3,  0, 0, 1);
    add(8'h04, 5'd3,  0, 0, 2);
    add(8'h08, 5'd3,  0, 0, 3);
    add(8'h10, 5'd3,  1, 0, 4);
    add(8'h20, 5'd3,  1, 0, 5);
    add(8'h40, 5'd3,  1, 0, 6);
    add(8'h80, 5'd3,  1, 0, 7);
    add(8'h01, 5'd3,  1, 0, 8);
    // COUNT, including the FF->00 wrap
    add(8'hFD, 5'd31, 0, 1, 0);
    add(8'hFE, 5'd13, 0, 0, 1);
    add(8'hFF, 5'd13, 0, 0, 2);
    add(8'h00, 5'd13, 0, 0, 3);
    add(8'h01, 5'd13, 1, 0, 4);
    add(8'h02, 5'd13, 1, 0, 5);
    // BLINK, then the FF,FF break to ON and relock
    add(8'h00, 5'd31, 0, 1, 0);
    add(8'hFF, 5'd2,  0, 0, 1);
    add(8'h00, 5'd2,  0, 0, 2);
    add(8'hFF, 5'd2,  0, 0, 3);
    add(8'h00, 5'd2,  1, 0, 4);
    add(8'hFF, 5'd2,  1, 0, 5);
    add(8'hFF, 5'd1,  0, 1, 1);
    add(8'hFF, 5'd1,  0, 0, 2);
    add(8'hFF, 5'd1,  0, 0, 3);
    add(8'hFF, 5'd1,  1, 0, 4);
    for (int r = 5; r <= 15; r++) add(8'hFF, 5'd1, 1, 0, 4'(r));
    add(8'hFF, 5'd1,  1, 0, 15);
    add(8'hFF, 5'd1,  1, 0, 15);
    // ALT, then unrecognised data
    add(8'hAA, 5'd31, 0, 1, 0);
    add(8'h55, 5'd4,  0, 0, 1);
    add(8'hAA, 5'd4,  0, 0, 2);
    add(8'h55, 5'd4,  0, 0, 3);
    add(8'hAA, 5'd4,  1, 0, 4);
    add(rnd[0], 5'd31, 0, 1, 0);
    for (int i = 1; i < 12; i++) add(rnd[i], 5'd31, 0, 0, 0);
    // NEGRUN
    add(8'hFE, 5'd31, 0, 0, 0);
    add(8'hFD, 5'd5,  0, 0, 1);
    add(8'hFB, 5'd5,  0, 0, 2);
    add(8'hF7, 5'd5,  0, 0, 3);
    add(8'hEF, 5'd5,  1, 0, 4);

    bus.led_in = 8'h00;
    bus.step   = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 5'd31, 0, 0, 0);
    rst_n = 1'b1;

    foreach (vecs[i])
      do_step($sformatf("vec%0d", i), vecs[i].led, vecs[i].pid, vecs[i].lk, vecs[i].ls, vecs[i].rl);

    // Timeout: one idle cycle already elapsed, so the 16th idle edge is 15 more away
    for (int k = 2; k < TIMEOUT; k++) begin
      idle_cycle();
      check($sformatf("pre_timeout%0d locked", k), 32'(bus.locked), 32'h1);
      check($sformatf("pre_timeout%0d lost", k),   32'(bus.lost),   32'h0);
    end
    idle_cycle();
    check_outs("timeout", 5'd31, 0, 1, 0);
    idle_cycle();
    check_outs("after_timeout", 5'd31, 0, 0, 0);

    // Back in IDLE: the first step only loads prev, then RUN relocks
    do_step("idle_load", 8'h01, 5'd31, 0, 0, 0);
    do_step("relock1",   8'h02, 5'd3,  0, 0, 1);
    do_step("relock2",   8'h04, 5'd3,  0, 0, 2);
    do_step("relock3",   8'h08, 5'd3,  0, 0, 3);
    do_step("relock4",   8'h10, 5'd3,  1, 0, 4);

    // Reset coinciding with a step: the reset wins and the step is dropped
    rst_n      = 1'b0;
    bus.led_in = 8'h20;
    bus.step   = 1'b1;
    @(posedge clk); #1;
    check_outs("mid_reset", 5'd31, 0, 0, 0);
    rst_n    = 1'b1;
    bus.step = 1'b0;
    @(posedge clk); #1;
    check_outs("post_reset_idle", 5'd31, 0, 0, 0);
    do_step("post_reset_load", 8'h40, 5'd31, 0, 0, 0);
    do_step("post_reset_run",  8'h80, 5'd3,  0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_pattern_classifier.md
Name: led_pattern_classifier

Overview:
- Receive-side monitor for the multi-pattern LED sequencer.
- Watches the 8-bit LED bus once per sequencer step and identifies which pattern is running, reported in the sequencer's 5-bit pattern_sel encoding.
- Used on-chip for self-check and in loopback benches: the sequencer's uo_out is fed to led_in and its step tick to step.

Parameters:
- LOCK_STEPS, 4, consecutive consistent steps needed before locked asserts (range 2..15).
- TIMEOUT_CYCLES, 65535, clocks without a step pulse before lock is dropped; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- led_in  input  8  LED bus from the sequencer
- step  input  1  single-cycle pulse; led_in is valid and sampled on this cycle
- pattern_id  output  5  detected pattern code; 31 = unknown
- locked  output  1  high while pattern_id is trusted
- lost  output  1  one-cycle pulse when lock is dropped
- run_len  output  4  consecutive consistent steps, saturating at 15

Behaviour:
- Reset (rst_n low at a clk edge) applies mid-operation as well.
  - Outputs: pattern_id=31, locked=0, lost=0, run_len=0.
  - Internal: prev register=0, candidate mask=0, timeout counter=0, state=IDLE.
- All outputs are registered. A step on cycle N is reflected in the outputs after edge N+1. Cycles with step=0 change nothing except the timeout counter.
- Per-step match mask, computed from prev sample p and current sample c:
  - bit0 OFF (code 0): p=00, c=00.
  - bit1 ON (code 1): p=FF, c=FF.
  - bit2 BLINK (code 2): {p,c} = {00,FF} or {FF,00}.
  - bit3 RUN (code 3): p one-hot and c = rotl(p,1).
  - bit4 ALT (code 4): p ∈ {AA,55} and c = ~p.
  - bit5 NEGRUN (code 5): ~p one-hot and c = rotl(p,1).
  - bit6 COUNT (code 13): c = p+1 mod 256, so FF→00 matches.
- States:
  - IDLE (no valid prev). On step: store p=c and go to TRACK. Mask, run_len and pattern_id are unchanged.
  - TRACK. On step: m = mask & match.
    - If m≠0: mask=m, run_len+1 (saturating).
    - If m=0: mask=match and run_len = (match≠0 ? 1 : 0).
    - pattern_id = lowest set bit of mask mapped to its code, or 31 if mask=0.
    - When run_len reaches LOCK_STEPS and mask is one-hot: go to LOCKED, locked=1.
  - LOCKED. On step:
    - If match has the locked bit: run_len+1 (saturating).
    - Otherwise: locked=0, lost pulses for one cycle, then go to TRACK with mask=match, run_len=(match≠0 ? 1 : 0), and pattern_id recomputed.
- prev is updated to c on every step in every state.
- Ambiguity: 01→02 matches both RUN and COUNT. Lock is withheld until the mask is one-hot, even if run_len ≥ LOCK_STEPS.
- Timeout: the counter clears on every step and otherwise increments, saturating.
  - When it reaches TIMEOUT_CYCLES in LOCKED: locked=0, lost pulses, pattern_id=31, mask=0, run_len=0, state=IDLE.
  - When it reaches TIMEOUT_CYCLES in TRACK: the same reset to IDLE, with no lost pulse.
  - A step arriving on the same cycle as the timeout wins: the step is processed and the counter cleared.
- Unrecognised patterns (LFSR, heartbeat, etc.) yield mask=0: pattern_id=31, locked=0.

Test Plan:
- Reset, then step with led_in = 01,02,04,08,10,20 (LOCK_STEPS=4). After the 02→04 step: mask=RUN only. After the 5th step: pattern_id=3, locked=1. Continue 40→80→01 wrap: locked stays 1.
- Counter sequence FD,FE,FF,00,01,02 → pattern_id=13, locked=1 after step 5; the FF→00 step is counted consistent.
- Blink 00,FF,00,FF,00 → locked with pattern_id=2. Then feed FF,FF → lost pulses exactly one cycle, locked=0. Continue FF,FF,FF,FF → relock with pattern_id=1.
- Locked on ALT (AA,55,AA,55,AA), then 12 steps of pseudo-random values → lost pulse, pattern_id=31, run_len=0, locked never reasserts.
- Locked on NEGRUN (FE,FD,FB,F7,EF), then no step for TIMEOUT_CYCLES (use 16) → lost pulse on the timeout edge, pattern_id=31, state IDLE. Next step only loads prev; outputs are unchanged.
- rst_n low for one cycle while locked, coinciding with a step → after that edge all outputs are at reset values and the step is ignored.
